// File: rtl/i2c_txn_monitor.sv
// Passive I2C monitor: decodes register reads/writes to one slave address into
// per-byte transaction records; never drives the bus.
module i2c_txn_monitor #(
    parameter logic [6:0]  DEV_ADDR      = 7'h40,
    parameter int unsigned STALL_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda,
    output logic       txn_valid,
    output logic       txn_is_read,
    output logic [7:0] txn_addr,
    output logic [7:0] txn_wdata,
    output logic [7:0] txn_rdata,
    output logic       bus_busy,
    output logic       protocol_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEVADR = 3'd1,
        S_REGADR = 3'd2,
        S_WDATA  = 3'd3,
        S_RDATA  = 3'd4,
        S_SKIP   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;
    logic [7:0]  r_shift;
    logic [3:0]  r_cnt;
    logic        r_bit_seen;
    logic [7:0]  r_ptr;
    logic [31:0] r_stall_cnt;
    logic        r_busy;
    logic        r_txn_valid, r_txn_is_read, r_perr;
    logic [7:0]  r_txn_addr, r_txn_wdata, r_txn_rdata;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_ack, w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_ack      = ~r_sda_s2;
    assign w_timeout  = r_busy && (r_stall_cnt == STALL_TIMEOUT);

    // r_cnt counts completed bits (advanced on the falling edge), so the SCL rise
    // that precedes a STOP or repeated START after an ACK leaves the counter at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift       <= 8'h00;
            r_cnt         <= 4'd0;
            r_bit_seen    <= 1'b0;
            r_ptr         <= 8'h00;
            r_stall_cnt   <= 32'd0;
            r_busy        <= 1'b0;
            r_txn_valid   <= 1'b0;
            r_txn_is_read <= 1'b0;
            r_txn_addr    <= 8'h00;
            r_txn_wdata   <= 8'h00;
            r_txn_rdata   <= 8'h00;
            r_perr        <= 1'b0;
        end else begin
            r_txn_valid <= 1'b0;
            r_perr      <= 1'b0;

            if (!r_busy || w_scl_rise || w_scl_fall || w_start || w_stop)
                r_stall_cnt <= 32'd0;
            else
                r_stall_cnt <= r_stall_cnt + 32'd1;

            if (w_timeout) begin
                r_perr      <= 1'b1;
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_cnt       <= 4'd0;
                r_bit_seen  <= 1'b0;
                r_stall_cnt <= 32'd0;
            end else if (w_start) begin
                if (r_cnt != 4'd0)
                    r_perr <= 1'b1;
                r_state    <= S_DEVADR;
                r_busy     <= 1'b1;
                r_cnt      <= 4'd0;
                r_bit_seen <= 1'b0;
            end else if (w_stop) begin
                if (r_cnt != 4'd0)
                    r_perr <= 1'b1;
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_cnt      <= 4'd0;
                r_bit_seen <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_scl_rise) begin
                    r_bit_seen <= 1'b1;
                    if (r_cnt != 4'd8) begin
                        r_shift <= {r_shift[6:0], r_sda_s2};
                    end else begin
                        case (r_state)
                            S_DEVADR: begin
                                if (r_shift[7:1] == DEV_ADDR && w_ack)
                                    r_state <= r_shift[0] ? S_RDATA : S_REGADR;
                                else
                                    r_state <= S_SKIP;
                            end
                            S_REGADR: begin
                                if (w_ack) begin
                                    r_ptr   <= r_shift;
                                    r_state <= S_WDATA;
                                end else begin
                                    r_state <= S_SKIP;
                                end
                            end
                            S_WDATA: begin
                                if (w_ack) begin
                                    r_txn_valid   <= 1'b1;
                                    r_txn_is_read <= 1'b0;
                                    r_txn_addr    <= r_ptr;
                                    r_txn_wdata   <= r_shift;
                                    r_txn_rdata   <= 8'h00;
                                    r_ptr         <= r_ptr + 8'd1;
                                end else begin
                                    r_state <= S_SKIP;
                                end
                            end
                            S_RDATA: begin
                                r_txn_valid   <= 1'b1;
                                r_txn_is_read <= 1'b1;
                                r_txn_addr    <= r_ptr;
                                r_txn_wdata   <= 8'h00;
                                r_txn_rdata   <= r_shift;
                                r_ptr         <= r_ptr + 8'd1;
                                if (!w_ack)
                                    r_state <= S_SKIP;
                            end
                            default: ;
                        endcase
                    end
                end else if (w_scl_fall && r_bit_seen) begin
                    r_bit_seen <= 1'b0;
                    r_cnt      <= (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
                end
            end
        end
    end

    assign txn_valid    = r_txn_valid;
    assign txn_is_read  = r_txn_is_read;
    assign txn_addr     = r_txn_addr;
    assign txn_wdata    = r_txn_wdata;
    assign txn_rdata    = r_txn_rdata;
    assign bus_busy     = r_busy;
    assign protocol_err = r_perr;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_i2c_txn_monitor.sv
// Directed bench for i2c_txn_monitor: bit-banged I2C frames, expected-record
// queue checked on every txn_valid pulse, plus direct checks of latency and flags.
module tb_i2c_txn_monitor;

    localparam int unsigned STALL = 200;

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda;
    logic       txn_valid;
    logic       txn_is_read;
    logic [7:0] txn_addr;
    logic [7:0] txn_wdata;
    logic [7:0] txn_rdata;
    logic       bus_busy;
    logic       protocol_err;
    logic [2:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int perr_cnt    = 0;
    int perr_base;

    // record layout: {is_read, addr, wdata, rdata}
    logic [24:0] exp_q[$];
    logic [24:0] got_rec;
    logic [24:0] exp_rec;

    i2c_txn_monitor #(
        .DEV_ADDR      (7'h40),
        .STALL_TIMEOUT (STALL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scl          (scl),
        .sda          (sda),
        .txn_valid    (txn_valid),
        .txn_is_read  (txn_is_read),
        .txn_addr     (txn_addr),
        .txn_wdata    (txn_wdata),
        .txn_rdata    (txn_rdata),
        .bus_busy     (bus_busy),
        .protocol_err (protocol_err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: every pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && protocol_err)
            perr_cnt++;
        if (!rst && txn_valid) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL txn_unexpected: observed {rd=%0b addr=%h wd=%h rd=%h} expected none",
                       txn_is_read, txn_addr, txn_wdata, txn_rdata);
            end
            if (exp_q.size() != 0) begin
                got_rec = {txn_is_read, txn_addr, txn_wdata, txn_rdata};
                exp_rec = exp_q.pop_front();
                vectors++;
                assert (got_rec === exp_rec) else begin
                    miscompares++;
                    $error("FAIL txn_record: observed %h expected %h", got_rec, exp_rec);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda = 1'b1; half();
        scl = 1'b1; half();
        sda = 1'b0; half();
        scl = 1'b0; half();
    endtask

    task automatic i2c_stop();
        sda = 1'b0; half();
        scl = 1'b1; half();
        sda = 1'b1; half();
    endtask

    task automatic send_bit(input logic b);
        sda = b;    half();
        scl = 1'b1; half();
        scl = 1'b0; half();
    endtask

    // 8 data bits then the ACK bit; also checks the 3-cycle pulse latency
    task automatic send_byte(input logic [7:0] d, input logic ack, input logic exp_txn,
                             input string tag);
        for (int i = 7; i >= 0; i--)
            send_bit(d[i]);
        sda = ack ? 1'b0 : 1'b1;
        half();
        scl = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk({tag, "_early"}, {31'd0, txn_valid}, 32'd0);
        @(posedge clk);
        #1 chk({tag, "_lat"}, {31'd0, txn_valid}, {31'd0, exp_txn});
        half();
        scl = 1'b0;
        half();
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d, 8'h00});
    endtask

    task automatic exp_rd(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, 8'h00, d});
    endtask

    initial begin
        rst = 1'b1;
        scl = 1'b1;
        sda = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, txn_valid}, 32'd0);
        chk("rst_is_read", {31'd0, txn_is_read}, 32'd0);
        chk("rst_addr", {24'd0, txn_addr}, 32'd0);
        chk("rst_wdata", {24'd0, txn_wdata}, 32'd0);
        chk("rst_rdata", {24'd0, txn_rdata}, 32'd0);
        chk("rst_busy", {31'd0, bus_busy}, 32'd0);
        chk("rst_perr", {31'd0, protocol_err}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single write: reg 0x10 <= 0xA5
        i2c_start();
        chk("t1_busy", {31'd0, bus_busy}, 32'd1);
        chk("t1_state_devadr", {29'd0, dbg_state}, 32'd1);
        send_byte(8'h80, 1'b1, 1'b0, "t1_dev");
        send_byte(8'h10, 1'b1, 1'b0, "t1_reg");
        exp_wr(8'h10, 8'hA5);
        send_byte(8'hA5, 1'b1, 1'b1, "t1_data");
        i2c_stop();
        chk("t1_idle", {31'd0, bus_busy}, 32'd0);
        chk("t1_hold_addr", {24'd0, txn_addr}, 32'h10);
        chk("t1_hold_wdata", {24'd0, txn_wdata}, 32'hA5);
        chk("t1_perr", perr_cnt, 0);

        // current-address read shows the pointer advanced to 0x11
        i2c_start();
        send_byte(8'h81, 1'b1, 1'b0, "t1r_dev");
        exp_rd(8'h11, 8'h3C);
        send_byte(8'h3C, 1'b0, 1'b1, "t1r_data");
        i2c_stop();

        // pointer write then repeated-START read, ACK then NACK
        i2c_start();
        send_byte(8'h80, 1'b1, 1'b0, "t2_dev");
        send_byte(8'h00, 1'b1, 1'b0, "t2_reg");
        i2c_start();
        send_byte(8'h81, 1'b1, 1'b0, "t2_devr");
        exp_rd(8'h00, 8'hA7);
        send_byte(8'hA7, 1'b1, 1'b1, "t2_rd0");
        exp_rd(8'h01, 8'h01);
        send_byte(8'h01, 1'b0, 1'b1, "t2_rd1");
        i2c_stop();
        chk("t2_perr", perr_cnt, 0);

        // burst write across the 0xFF -> 0x00 pointer wrap
        i2c_start();
        send_byte(8'h80, 1'b1, 1'b0, "t3_dev");
        send_byte(8'hFF, 1'b1, 1'b0, "t3_reg");
        exp_wr(8'hFF, 8'h5A);
        send_byte(8'h5A, 1'b1, 1'b1, "t3_d0");
        exp_wr(8'h00, 8'h5B);
        send_byte(8'h5B, 1'b1, 1'b1, "t3_d1");
        i2c_stop();
        chk("t3_perr", perr_cnt, 0);

        // other device (0x30) is ignored, then 0x40 still decodes
        i2c_start();
        send_byte(8'h60, 1'b1, 1'b0, "t4_dev");
        chk("t4_state_skip", {29'd0, dbg_state}, 32'd5);
        send_byte(8'h11, 1'b1, 1'b0, "t4_data");
        chk("t4_busy", {31'd0, bus_busy}, 32'd1);
        i2c_stop();
        chk("t4_idle", {31'd0, bus_busy}, 32'd0);
        i2c_start();
        send_byte(8'h80, 1'b1, 1'b0, "t4b_dev");
        send_byte(8'h20, 1'b1, 1'b0, "t4b_reg");
        exp_wr(8'h20, 8'hC3);
        send_byte(8'hC3, 1'b1, 1'b1, "t4b_data");
        i2c_stop();
        chk("t4_perr", perr_cnt, 0);

        // STOP after 4 bits of a data byte
        perr_base = perr_cnt;
        i2c_start();
        send_byte(8'h80, 1'b1, 1'b0, "t5_dev");
        send_byte(8'h30, 1'b1, 1'b0, "t5_reg");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_stop();
        chk("t5_perr_once", perr_cnt - perr_base, 1);
        chk("t5_idle", {31'd0, bus_busy}, 32'd0);
        i2c_start();
        send_byte(8'h80, 1'b1, 1'b0, "t5b_dev");
        send_byte(8'h40, 1'b1, 1'b0, "t5b_reg");
        exp_wr(8'h40, 8'h99);
        send_byte(8'h99, 1'b1, 1'b1, "t5b_data");
        i2c_stop();
        chk("t5b_perr", perr_cnt - perr_base, 1);

        // stall: SCL held low after START
        perr_base = perr_cnt;
        i2c_start();
        chk("t6_busy", {31'd0, bus_busy}, 32'd1);
        repeat (STALL + 5) @(negedge clk);
        chk("t6_perr", perr_cnt - perr_base, 1);
        chk("t6_idle", {31'd0, bus_busy}, 32'd0);
        chk("t6_state", {29'd0, dbg_state}, 32'd0);
        i2c_stop();
        chk("t6_stop_noerr", perr_cnt - perr_base, 1);

        // reset in the middle of a byte
        i2c_start();
        send_byte(8'h80, 1'b1, 1'b0, "t7_dev");
        send_byte(8'h50, 1'b1, 1'b0, "t7_reg");
        exp_wr(8'h50, 8'h77);
        send_byte(8'h77, 1'b1, 1'b1, "t7_data");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t7_rst_valid", {31'd0, txn_valid}, 32'd0);
        chk("t7_rst_addr", {24'd0, txn_addr}, 32'd0);
        chk("t7_rst_wdata", {24'd0, txn_wdata}, 32'd0);
        chk("t7_rst_busy", {31'd0, bus_busy}, 32'd0);
        chk("t7_rst_perr", {31'd0, protocol_err}, 32'd0);
        chk("t7_rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        perr_base = perr_cnt;
        i2c_start();
        send_byte(8'h81, 1'b1, 1'b0, "t7r_dev");
        exp_rd(8'h00, 8'h5E);
        send_byte(8'h5E, 1'b0, 1'b1, "t7r_data");
        i2c_stop();
        chk("t7_perr", perr_cnt - perr_base, 0);

        repeat (10) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
